sc_response_checker: RTL and testbench
======================================

SC_RESPONSE_CHECKER -- requirements
Module: sc_response_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets the cycles stim is held before the response is compared; legal range 1..15.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port start  input  1  run request, level-sampled at the rising edge of clk.
REQ-005 Port resp  input  4  DUT response {E,F,G,H}, MSB = E.
REQ-006 Port stim  output  3  DUT stimulus {A,B,C}, MSB = A.
REQ-007 Port busy  output  1  high while a run is in progress.
REQ-008 Port done  output  1  high from run completion until the next run starts or reset.
REQ-009 Port pass  output  1  valid when done=1; 1 = zero mismatches.
REQ-010 Port mismatch_cnt  output  4  count of failing vectors in the current run, 0..8.
REQ-011 Port first_fail_vec  output  3  stim value of the first failing vector.
REQ-012 Port first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-013 Golden model, per vector {A,B,C}: E=A&B; F=A|C; G=~C; H=A&B&C.
REQ-014 States: IDLE, SETTLE, COMPARE, DONE; encoding is free.
REQ-015 IDLE or DONE with start=1 -> SETTLE; on the same edge: stim<=0, settle counter<=SETTLE_CYCLES, mismatch_cnt<=0, first_fail_valid<=0, first_fail_vec<=0, done<=0.
REQ-016 SETTLE: the counter decrements each cycle; when it equals 1, the state moves to COMPARE on the next edge.
REQ-017 COMPARE: one edge samples resp and compares all 4 bits with the golden value for the current stim.
REQ-018 Mismatch: mismatch_cnt increments; if first_fail_valid=0, first_fail_vec<=stim and first_fail_valid<=1.
REQ-019 COMPARE with stim!=7 -> SETTLE; on the same edge: stim<=stim+1 and counter<=SETTLE_CYCLES.
REQ-020 COMPARE with stim=7 -> DONE; stim stays 7; done<=1.
REQ-021 Per-vector cost is SETTLE_CYCLES+1 cycles; done rises 8*(SETTLE_CYCLES+1) edges after the start edge.
REQ-022 busy=1 exactly in SETTLE and COMPARE; start is ignored while busy=1.
REQ-023 pass = done & (mismatch_cnt==0); pass=0 whenever done=0.
REQ-024 Results (mismatch_cnt, first_fail_*) hold their values in DONE until the next start; stim holds its last value in DONE.
REQ-025 mismatch_cnt never wraps; the maximum is 8.

Reset
REQ-026 When rst_n=0, all outputs go to 0 immediately and the state goes to IDLE, regardless of clk.
REQ-027 Reset mid-run aborts the run with no result retained; a new start is required after rst_n deasserts.
REQ-028 The first start is accepted at the first rising edge with rst_n=1 and start=1.

Configuration
REQ-029 Macro SC_CHECK_EARLY_ABORT_EN.
- Defined: the first mismatch in COMPARE moves directly to DONE (done<=1), with mismatch_cnt=1 and first_fail captured.
- Undefined: all 8 vectors always run.

Verification
REQ-030 SETTLE_CYCLES=2, resp driven by the golden model with 1-cycle delay, start pulse -> done at edge 24; pass=1; mismatch_cnt=0; first_fail_valid=0; stim sequence 0..7.
REQ-031 H forced to 1 -> mismatch_cnt=7 (vectors 0..6), first_fail_vec=0, pass=0; with SC_CHECK_EARLY_ABORT_EN -> done after 3 cycles, mismatch_cnt=1.
REQ-032 E inverted only when stim=5 (golden resp 4'b0100) -> mismatch_cnt=1, first_fail_vec=5, first_fail_valid=1.
REQ-033 rst_n pulsed low during vector 3 -> all outputs 0 asynchronously; IDLE; next start restarts at stim=0 and yields a clean pass.
REQ-034 start held high for the whole run -> no restart while busy; after done, a further start clears results and begins a new run.
REQ-035 SETTLE_CYCLES=1 and SETTLE_CYCLES=15 -> done at edges 16 and 128 respectively, with correct pass.

Source files
------------

// File: rtl/sc_response_checker.sv
// Sequencer that walks the 3-bit stimulus 0..7, compares the 4-bit response against the
// golden logic after a settle delay, and reports pass / mismatch count / first failure.
// Optional build macro: SC_CHECK_EARLY_ABORT_EN (stop at the first mismatching vector).
module sc_response_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] resp,
    output logic [2:0] stim,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [3:0] CNT_MAX     = 4'd8;

    state_t     state_q, state_d;
    logic [2:0] stim_q, stim_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mcnt_q, mcnt_d;
    logic [2:0] ffvec_q, ffvec_d;
    logic       ffvld_q, ffvld_d;
    logic       done_q, done_d;
    logic       mism;

    // Expected response {E,F,G,H} for stimulus {A,B,C}.
    function automatic logic [3:0] golden(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return {a & b, a | c, ~c, a & b & c};
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 4'd1;
    endfunction

    assign mism = (resp != golden(stim_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            ffvec_q <= '0;
            ffvld_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            ffvec_q <= ffvec_d;
            ffvld_q <= ffvld_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        ffvec_d = ffvec_q;
        ffvld_d = ffvld_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    stim_d  = '0;
                    cnt_d   = SETTLE_INIT;
                    mcnt_d  = '0;
                    ffvec_d = '0;
                    ffvld_d = 1'b0;
                    done_d  = 1'b0;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (mism) begin
                    mcnt_d = sat_inc(mcnt_q);
                    if (!ffvld_q) begin
                        ffvec_d = stim_q;
                        ffvld_d = 1'b1;
                    end
                end
`ifdef SC_CHECK_EARLY_ABORT_EN
                if (mism) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else
`endif
                if (stim_q == 3'd7) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    stim_d  = stim_q + 3'd1;
                    cnt_d   = SETTLE_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stim             = stim_q;
    assign busy             = (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
    assign done             = done_q;
    assign pass             = done_q && (mcnt_q == 4'd0);
    assign mismatch_cnt     = mcnt_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffvld_q;

endmodule

// File: tb/tb_sc_response_checker.sv
// Bench for sc_response_checker: three instances (settle 2, 1, 15) driven by a registered
// response model with per-vector fault injection; table, directed and random runs.
module tb_sc_response_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [3];
    logic [3:0] resp  [3];
    logic [2:0] stim  [3];
    logic       busy  [3];
    logic       done  [3];
    logic       pass  [3];
    logic [3:0] mcnt  [3];
    logic [2:0] ffvec [3];
    logic       ffvld [3];
    logic [3:0] fxor  [3][8];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Golden response written from the arithmetic meaning of each output bit.
    function automatic logic [3:0] gold(input int v);
        logic e, f, g, h;
        e = (v >= 6);
        f = (v >= 4) || (v % 2 == 1);
        g = (v % 2 == 0);
        h = (v == 7);
        return {e, f, g, h};
    endfunction

    function automatic int scyc(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int SC = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;
            sc_response_checker #(.SETTLE_CYCLES(SC)) u_dut (
                .clk             (clk),
                .rst_n           (rst_n),
                .start           (start[gi]),
                .resp            (resp[gi]),
                .stim            (stim[gi]),
                .busy            (busy[gi]),
                .done            (done[gi]),
                .pass            (pass[gi]),
                .mismatch_cnt    (mcnt[gi]),
                .first_fail_vec  (ffvec[gi]),
                .first_fail_valid(ffvld[gi])
            );
        end
    endgenerate

    // Device-under-check model: golden response with one cycle of delay plus injected faults.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            resp[k] <= gold(int'(stim[k])) ^ fxor[k][stim[k]];
    end

    typedef struct {
        int done_edge;
        int pass;
        int mcnt;
        int ffvld;
        int ffvec;
        int last_stim;
    } exp_t;

    typedef struct {
        int   k;
        int   mode;
        exp_t e;
    } vec_t;

    // Reference: judge the whole run from the fault table in one pass.
    function automatic exp_t model(input int k);
        exp_t r;
        int   s;
        s = scyc(k);
        r = '{8 * (s + 1), 1, 0, 0, 0, 7};
        for (int v = 0; v < 8; v++) begin
            if (fxor[k][v] != 4'h0) begin
                r.mcnt++;
                if (r.ffvld == 0) begin
                    r.ffvld = 1;
                    r.ffvec = v;
                end
            end
        end
        r.pass = (r.mcnt == 0);
`ifdef SC_CHECK_EARLY_ABORT_EN
        if (r.ffvld == 1) begin
            r.mcnt      = 1;
            r.done_edge = (r.ffvec + 1) * (s + 1);
            r.last_stim = r.ffvec;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_faults(input int k);
        for (int v = 0; v < 8; v++) fxor[k][v] = 4'h0;
    endtask

    task automatic check_all_zero(input int k, input string tag);
        chk({tag, ".stim"},  int'(stim[k]), 0);
        chk({tag, ".busy"},  int'(busy[k]), 0);
        chk({tag, ".done"},  int'(done[k]), 0);
        chk({tag, ".pass"},  int'(pass[k]), 0);
        chk({tag, ".mcnt"},  int'(mcnt[k]), 0);
        chk({tag, ".ffvec"}, int'(ffvec[k]), 0);
        chk({tag, ".ffvld"}, int'(ffvld[k]), 0);
    endtask

    // Start a run and count rising edges from the start edge until done is seen.
    task automatic do_run(input int k, input bit hold, input int last, output int n);
        int q[$];
        int ok;
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start[k] = 1'b0;
        q.push_back(int'(stim[k]));
        n = 0;
        while (!done[k] && n < 300) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (int'(stim[k]) != q[q.size()-1]) q.push_back(int'(stim[k]));
        end
        if (!done[k]) chk("run.timeout", n, -1);
        ok = (q.size() == last + 1);
        for (int i = 0; i < q.size(); i++) if (q[i] != i) ok = 0;
        chk($sformatf("run%0d.stimseq", k), ok, 1);
    endtask

    task automatic run_check(input int k, input string tag, input exp_t e);
        int n;
        do_run(k, 1'b0, e.last_stim, n);
        chk({tag, ".done_edge"}, n, e.done_edge);
        chk({tag, ".pass"},  int'(pass[k]), e.pass);
        chk({tag, ".mcnt"},  int'(mcnt[k]), e.mcnt);
        chk({tag, ".ffvld"}, int'(ffvld[k]), e.ffvld);
        chk({tag, ".ffvec"}, int'(ffvec[k]), e.ffvec);
        chk({tag, ".stim"},  int'(stim[k]), e.last_stim);
        chk({tag, ".busy"},  int'(busy[k]), 0);
    endtask

    vec_t tbl[5];

    initial begin
        int         n;
        logic [3:0] g;
        exp_t       e;

        tbl[0] = '{0, 0, '{24, 1, 0, 0, 0, 7}};
`ifdef SC_CHECK_EARLY_ABORT_EN
        tbl[1] = '{0, 1, '{3, 0, 1, 1, 0, 0}};
        tbl[2] = '{0, 2, '{18, 0, 1, 1, 5, 5}};
`else
        tbl[1] = '{0, 1, '{24, 0, 7, 1, 0, 7}};
        tbl[2] = '{0, 2, '{24, 0, 1, 1, 5, 7}};
`endif
        tbl[3] = '{1, 0, '{16, 1, 0, 0, 0, 7}};
        tbl[4] = '{2, 0, '{128, 1, 0, 0, 0, 7}};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            clear_faults(k);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_all_zero(k, $sformatf("reset%0d", k));
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clear_faults(tbl[i].k);
            if (tbl[i].mode == 1) begin
                for (int v = 0; v < 8; v++) begin
                    g = gold(v);
                    fxor[tbl[i].k][v] = g[0] ? 4'h0 : 4'h1;
                end
            end else if (tbl[i].mode == 2) begin
                fxor[tbl[i].k][5] = 4'h8;
            end
            run_check(tbl[i].k, $sformatf("tbl%0d", i), tbl[i].e);
        end

        // Asynchronous reset in the middle of vector 3, then a clean rerun.
        clear_faults(0);
`ifndef SC_CHECK_EARLY_ABORT_EN
        fxor[0][1] = 4'h2;
`endif
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (stim[0] != 3'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.reach3", int'(stim[0]), 3);
        #2 rst_n = 1'b0;
        #1 check_all_zero(0, "midrst");
        @(negedge clk);
        chk("midrst.held.busy", int'(busy[0]), 0);
        rst_n = 1'b1;
        clear_faults(0);
        run_check(0, "postrst", '{24, 1, 0, 0, 0, 7});

        // Start held high: no restart while busy, restart right after done.
        clear_faults(0);
        fxor[0][5] = 4'h8;
        e = model(0);
        do_run(0, 1'b1, e.last_stim, n);
        chk("hold.done_edge", n, e.done_edge);
        chk("hold.mcnt", int'(mcnt[0]), 1);
        chk("hold.pass", int'(pass[0]), 0);
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        chk("hold.restart.done",  int'(done[0]), 0);
        chk("hold.restart.busy",  int'(busy[0]), 1);
        chk("hold.restart.mcnt",  int'(mcnt[0]), 0);
        chk("hold.restart.ffvld", int'(ffvld[0]), 0);
        chk("hold.restart.stim",  int'(stim[0]), 0);
        n = 0;
        while (!done[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("hold.rerun.mcnt",  int'(mcnt[0]), 1);
        chk("hold.rerun.ffvec", int'(ffvec[0]), 5);

        // Random fault patterns on random instances.
        for (int i = 0; i < 12; i++) begin
            int k;
            k = $urandom_range(0, 2);
            for (int v = 0; v < 8; v++)
                fxor[k][v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_check(k, $sformatf("rnd%0d", i), model(k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
